// File: rtl/mul_pkg.sv
// Shared constants and types for the multiplier issue/retire controller.
package mul_pkg;

    localparam int MUL_LAT = 2;
    localparam int MUL_RW  = 5;
    localparam int MUL_CW  = 16;

    typedef logic [MUL_RW-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
    } slot_t;

endpackage

// File: rtl/mul_tag_pipe.sv
// Valid/destination shadow of the multiplier registers: shifts in lockstep
// with the datapath, holds on stall, and drops all valid bits on clear.
module mul_tag_pipe #(
    parameter int LAT = 2,
    parameter int RW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [RW-1:0]     in_rd,
    output logic [LAT-1:0]    v,
    output logic [LAT*RW-1:0] rd_flat
);

    logic [LAT-1:0] v_r;
    logic [RW-1:0]  rd_r [LAT];

    // Slot registers: reset, clear (valid only), hold, or shift by one stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r <= '0;
            for (int k = 0; k < LAT; k++) begin
                rd_r[k] <= '0;
            end
        end else if (clear) begin
            v_r <= '0;
        end else if (!hold) begin
            v_r[0]  <= in_valid;
            rd_r[0] <= in_rd;
            for (int k = 1; k < LAT; k++) begin
                v_r[k]  <= v_r[k-1];
                rd_r[k] <= rd_r[k-1];
            end
        end
    end

    assign v = v_r;

    for (genvar k = 0; k < LAT; k++) begin : g_flat
        assign rd_flat[k*RW +: RW] = rd_r[k];
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/retire sequencing for the pipelined multiplier: handshake, global
// stall, RAW hazard / forward detection and saturating performance counters.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int LAT = MUL_LAT,
    parameter int RW  = MUL_RW,
    parameter int CW  = MUL_CW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [RW-1:0]            req_rd,
    input  logic                     flush,
    output logic                     mul_stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RW-1:0]            out_rd,
    input  logic [RW-1:0]            dec_rs1,
    input  logic [RW-1:0]            dec_rs2,
    input  logic [1:0]               dec_rs_en,
    output logic                     raw_hazard,
    output logic                     fwd_hit,
    output logic [$clog2(LAT+1)-1:0] inflight,
    output logic [CW-1:0]            mul_cnt,
    output logic [CW-1:0]            stall_cnt
);

    localparam int IW = $clog2(LAT+1);

    logic [LAT-1:0]    v_s;
    logic [LAT*RW-1:0] rd_flat_s;
    logic [RW-1:0]     rd_s [LAT];
    logic              accept_s;
    logic              retire_s;
    logic              stall_s;
    logic [RW-1:0]     src_s [2];
    logic [1:0]        src_live_s;
    logic              raw_any_s;
    logic              fwd_any_s;
    logic [IW-1:0]     inflight_s;
    logic [CW-1:0]     mul_cnt_r;
    logic [CW-1:0]     stall_cnt_r;

    mul_tag_pipe #(
        .LAT (LAT),
        .RW  (RW)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (stall_s),
        .clear    (flush),
        .in_valid (accept_s),
        .in_rd    (req_rd),
        .v        (v_s),
        .rd_flat  (rd_flat_s)
    );

    for (genvar k = 0; k < LAT; k++) begin : g_slot
        assign rd_s[k] = rd_flat_s[k*RW +: RW];
    end

    // The stall depends only on the head slot and writeback, never on req_valid.
    assign stall_s   = v_s[LAT-1] & ~out_ready;
    assign accept_s  = req_valid & ~stall_s & ~flush;
    assign retire_s  = v_s[LAT-1] & out_ready & ~flush;

    assign mul_stall = stall_s;
    assign req_ready = ~stall_s & ~flush;
    assign out_valid = v_s[LAT-1];
    assign out_rd    = rd_s[LAT-1];

    // Register 0 is hardwired, so it never creates a dependency.
    assign src_s[0]      = dec_rs1;
    assign src_s[1]      = dec_rs2;
    assign src_live_s[0] = dec_rs_en[0] & (dec_rs1 != {RW{1'b0}});
    assign src_live_s[1] = dec_rs_en[1] & (dec_rs2 != {RW{1'b0}});

    // Younger slots and the request being accepted must stall decode;
    // only the head slot has a product that can be forwarded.
    always_comb begin
        raw_any_s = 1'b0;
        fwd_any_s = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < LAT-1; k++) begin
                raw_any_s = raw_any_s | (src_live_s[s] & v_s[k] & (rd_s[k] == src_s[s]));
            end
            raw_any_s = raw_any_s | (src_live_s[s] & accept_s & (req_rd == src_s[s]));
            fwd_any_s = fwd_any_s | (src_live_s[s] & v_s[LAT-1] & (rd_s[LAT-1] == src_s[s]));
        end
    end

    assign raw_hazard = raw_any_s & ~flush;
    assign fwd_hit    = fwd_any_s & ~flush;

    // Population count of live slots.
    always_comb begin
        inflight_s = '0;
        for (int k = 0; k < LAT; k++) begin
            inflight_s = inflight_s + IW'(v_s[k]);
        end
    end

    assign inflight = inflight_s;

    // Retired-product counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_cnt_r <= '0;
        end else if (retire_s && !(&mul_cnt_r)) begin
            mul_cnt_r <= mul_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Stall-cycle counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (stall_s && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign mul_cnt   = mul_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed and randomized checks of mul_issue_ctrl against a queue-based model.
module tb_mul_issue_ctrl;

    localparam int LAT = 2;
    localparam int RW  = 5;
    localparam int CW  = 16;
    localparam int SAT = 65535;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [RW-1:0] req_rd;
    logic          flush;
    logic          mul_stall;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_rd;
    logic [RW-1:0] dec_rs1;
    logic [RW-1:0] dec_rs2;
    logic [1:0]    dec_rs_en;
    logic          raw_hazard;
    logic          fwd_hit;
    logic [1:0]    inflight;
    logic [CW-1:0] mul_cnt;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.LAT(LAT), .RW(RW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rd     (req_rd),
        .flush      (flush),
        .mul_stall  (mul_stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .dec_rs_en  (dec_rs_en),
        .raw_hazard (raw_hazard),
        .fwd_hit    (fwd_hit),
        .inflight   (inflight),
        .mul_cnt    (mul_cnt),
        .stall_cnt  (stall_cnt)
    );

    // Model: list of in-flight ops, each with its destination and current stage.
    typedef struct {
        logic [RW-1:0] rd;
        int            stage;
    } op_t;

    op_t           mq[$];
    int            m_mul;
    int            m_stall;
    int            n_cmp;
    int            n_bad;
    logic [RW-1:0] retired_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval(output bit ov, output logic [RW-1:0] ord, output bit stall,
                              output bit ready, output bit acc, output bit raw,
                              output bit fwd, output int infl);
        logic [RW-1:0] src;
        ov = 1'b0;
        ord = '0;
        foreach (mq[i]) begin
            if (mq[i].stage == LAT-1) begin
                ov = 1'b1;
                ord = mq[i].rd;
            end
        end
        stall = ov && !out_ready;
        ready = !stall && !flush;
        acc   = req_valid && ready;
        raw   = 1'b0;
        fwd   = 1'b0;
        for (int s = 0; s < 2; s++) begin
            src = (s == 0) ? dec_rs1 : dec_rs2;
            if (dec_rs_en[s] && src != 0) begin
                foreach (mq[i]) begin
                    if (mq[i].stage < LAT-1 && mq[i].rd == src) raw = 1'b1;
                end
                if (acc && req_rd == src) raw = 1'b1;
                if (ov && ord == src) fwd = 1'b1;
            end
        end
        if (flush) begin
            raw = 1'b0;
            fwd = 1'b0;
        end
        infl = mq.size();
    endtask

    task automatic tick(input bit do_chk);
        bit ov, stall, ready, acc, raw, fwd;
        logic [RW-1:0] ord;
        int infl;
        op_t nq[$];
        @(negedge clk);
        model_eval(ov, ord, stall, ready, acc, raw, fwd, infl);
        if (do_chk) begin
            chk("out_valid", out_valid, ov);
            if (ov) chk("out_rd", out_rd, ord);
            chk("mul_stall", mul_stall, stall);
            chk("req_ready", req_ready, ready);
            chk("raw_hazard", raw_hazard, raw);
            chk("fwd_hit", fwd_hit, fwd);
            chk("inflight", inflight, infl);
            chk("mul_cnt", mul_cnt, m_mul);
            chk("stall_cnt", stall_cnt, m_stall);
        end
        if (rst_n && out_valid === 1'b1 && out_ready && !flush) retired_q.push_back(out_rd);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_mul = 0;
            m_stall = 0;
        end else begin
            if (ov && out_ready && !flush && m_mul < SAT) m_mul++;
            if (stall && m_stall < SAT) m_stall++;
            if (flush) begin
                mq.delete();
            end else if (!stall) begin
                foreach (mq[i]) begin
                    if (mq[i].stage < LAT-1) nq.push_back('{rd: mq[i].rd, stage: mq[i].stage + 1});
                end
                if (acc) nq.push_back('{rd: req_rd, stage: 0});
                mq = nq;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        flush = 1'b0;
        dec_rs_en = 2'b00;
        tick(1'b1);
        rst_n = 1'b1;
        retired_q.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ov"}, out_valid, 1'b0);
        chk({tag, "_stall"}, mul_stall, 1'b0);
        chk({tag, "_ready"}, req_ready, 1'b1);
        chk({tag, "_ord"}, out_rd, 5'd0);
        chk({tag, "_infl"}, inflight, 2'd0);
        chk({tag, "_mulcnt"}, mul_cnt, 16'd0);
        chk({tag, "_stcnt"}, stall_cnt, 16'd0);
        chk({tag, "_raw"}, raw_hazard, 1'b0);
        chk({tag, "_fwd"}, fwd_hit, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_mul = 0;
        m_stall = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_rd = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        dec_rs1 = '0;
        dec_rs2 = '0;
        dec_rs_en = 2'b00;
        tick(1'b0);
        rst_n = 1'b1;
        chk_reset_state("por");
        flush = 1'b1;
        #1 chk("flush_ready", req_ready, 1'b0);
        flush = 1'b0;

        // Single issue.
        do_reset();
        req_valid = 1'b1; req_rd = 5'd5;
        tick(1'b1);
        req_valid = 1'b0;
        chk("single_early", out_valid, 1'b0);
        tick(1'b1);
        chk("single_ov", out_valid, 1'b1);
        chk("single_rd", out_rd, 5'd5);
        tick(1'b1);
        chk("single_pulse", out_valid, 1'b0);
        tick(1'b1);
        chk("single_cnt", mul_cnt, 16'd1);

        // Back-to-back with back-pressure.
        do_reset();
        req_valid = 1'b1; req_rd = 5'd1;
        tick(1'b1);
        req_rd = 5'd2;
        tick(1'b1);
        out_ready = 1'b0; req_rd = 5'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_stall", mul_stall, 1'b1);
            chk("bp_ready", req_ready, 1'b0);
            tick(1'b1);
        end
        out_ready = 1'b1;
        tick(1'b1);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1);
        chk("bp_stcnt", stall_cnt, 16'd4);
        chk("bp_nret", retired_q.size(), 32'd3);
        if (retired_q.size() == 3) begin
            chk("bp_ret0", retired_q[0], 5'd1);
            chk("bp_ret1", retired_q[1], 5'd2);
            chk("bp_ret2", retired_q[2], 5'd3);
        end

        // Hazard and forward.
        do_reset();
        req_valid = 1'b1; req_rd = 5'd7;
        tick(1'b1);
        req_valid = 1'b0; dec_rs1 = 5'd7; dec_rs_en = 2'b01;
        #1;
        chk("haz_raw", raw_hazard, 1'b1);
        chk("haz_nofwd", fwd_hit, 1'b0);
        tick(1'b1);
        chk("fwd_hit", fwd_hit, 1'b1);
        chk("fwd_noraw", raw_hazard, 1'b0);
        do_reset();
        req_valid = 1'b1; req_rd = 5'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rs_en = 2'b11;
        #1 chk("r0_acc_raw", raw_hazard, 1'b0);
        tick(1'b1);
        req_valid = 1'b0;
        #1 chk("r0_raw", raw_hazard, 1'b0);
        tick(1'b1);
        chk("r0_fwd", fwd_hit, 1'b0);
        dec_rs_en = 2'b00;

        // Flush with two in flight and a request presented.
        do_reset();
        req_valid = 1'b1; req_rd = 5'd9;
        tick(1'b1);
        req_rd = 5'd10;
        tick(1'b1);
        req_rd = 5'd11; flush = 1'b1;
        #1 chk("fl_ready", req_ready, 1'b0);
        tick(1'b1);
        flush = 1'b0; req_valid = 1'b0;
        chk("fl_infl", inflight, 2'd0);
        chk("fl_ov", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1);
        chk("fl_cnt", mul_cnt, 16'd0);
        chk("fl_nret", retired_q.size(), 32'd0);

        // Reset while stalled.
        do_reset();
        out_ready = 1'b0;
        req_valid = 1'b1; req_rd = 5'd3;
        tick(1'b1);
        req_rd = 5'd4;
        tick(1'b1);
        req_valid = 1'b0;
        tick(1'b1);
        chk("rs_stall", mul_stall, 1'b1);
        chk("rs_infl", inflight, 2'd2);
        rst_n = 1'b0;
        tick(1'b1);
        rst_n = 1'b1;
        chk_reset_state("rs");
        out_ready = 1'b1;
        req_valid = 1'b1; req_rd = 5'd6;
        tick(1'b1);
        req_valid = 1'b0;
        chk("rs_lat_early", out_valid, 1'b0);
        tick(1'b1);
        chk("rs_lat_ov", out_valid, 1'b1);
        chk("rs_lat_rd", out_rd, 5'd6);

        // Stall counter saturation.
        do_reset();
        out_ready = 1'b0;
        req_valid = 1'b1; req_rd = 5'd1;
        tick(1'b1);
        req_valid = 1'b0;
        tick(1'b1);
        for (int i = 0; i < 65540; i++) tick(1'b0);
        tick(1'b1);
        chk("sat_stcnt", stall_cnt, 16'hFFFF);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_rd    = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            dec_rs1   = 5'($urandom_range(0, 7));
            dec_rs2   = 5'($urandom_range(0, 7));
            dec_rs_en = 2'($urandom_range(0, 3));
            rst_n     = ($urandom_range(0, 249) != 0);
            tick(1'b1);
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
